// File: rtl/sky130_as_sc_hs__dfxbank.sv
// Multi-stage flip-flop bank with valid tags, occupancy count and scan chain.
// Optional supply checking: define SKY130_AS_SC_HS_POWER_CHECK_EN.
module sky130_as_sc_hs__dfxbank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                             CLK,
  input  logic                             RESET_B,
  input  logic                             DE,
  input  logic [WIDTH-1:0]                 D,
  input  logic                             VALID_I,
  input  logic                             SCE,
  input  logic                             SCD,
  output logic [WIDTH-1:0]                 Q,
  output logic                             VALID_O,
  output logic [$clog2(STAGES+1)-1:0]      OCC,
  output logic                             SCQ,
  input  logic                             VPWR,
  input  logic                             VGND,
  input  logic                             VPB,
  input  logic                             VNB
);

  localparam int unsigned N  = WIDTH * STAGES;
  localparam int unsigned OW = $clog2(STAGES + 1);

  // Stage k occupies bits [k*WIDTH +: WIDTH]; the scan chain is a plain
  // left shift of this vector, entering at bit 0 and leaving at bit N-1.
  logic [N-1:0]      data_q, data_d;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic              pwr_bad;
  logic              unused_sup;

  assign unused_sup = ^{VPWR, VGND, VPB, VNB};

`ifdef SKY130_AS_SC_HS_POWER_CHECK_EN
  assign pwr_bad = (VPWR !== 1'b1) || (VGND !== 1'b0);
`else
  assign pwr_bad = 1'b0;
`endif

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    occ_d  = occ_q;
    if (SCE) begin
      data_d    = data_q << 1;
      data_d[0] = SCD;
    end else if (DE) begin
      data_d             = data_q << WIDTH;
      data_d[WIDTH-1:0]  = D;
      vld_d              = vld_q << 1;
      vld_d[0]           = VALID_I;
      occ_d = occ_q + OW'(VALID_I) - OW'(vld_q[STAGES-1]);
    end
  end

  always_ff @(posedge CLK) begin
    if (pwr_bad) begin
      data_q <= 'x;
      vld_q  <= 'x;
      occ_q  <= 'x;
    end else if (!RESET_B) begin
      data_q <= {STAGES{RESET_VAL}};
      vld_q  <= '0;
      occ_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      occ_q  <= occ_d;
    end
  end

  always_comb begin
    Q       = data_q[N-1 -: WIDTH];
    VALID_O = vld_q[STAGES-1];
    OCC     = occ_q;
    SCQ     = data_q[N-1];
    if (pwr_bad) begin
      Q       = 'x;
      VALID_O = 1'bx;
      OCC     = 'x;
      SCQ     = 1'bx;
    end
  end

endmodule
